// File: rtl/downsampler_seq_pkg.sv
// Shared types and helpers for the downsampler frame sequencer:
// sequencer state encoding, counter width helpers and crop-origin clamping.
package downsampler_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARM    = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_SKIP   = 2'd3
   } seq_state_e;

   localparam int STATS_W = 16;

   // Column counter width for a given sensor line length (never below 1 bit).
   function automatic int col_w(input int sensor_width);
      return (sensor_width > 1) ? $clog2(sensor_width) : 1;
   endfunction

   // Row counter width for a given sensor frame height (never below 1 bit).
   function automatic int row_w(input int sensor_height);
      return (sensor_height > 1) ? $clog2(sensor_height) : 1;
   endfunction

   // Pull a crop origin back so the whole window stays inside the sensor.
   function automatic int unsigned clamp_start(input int unsigned start,
                                               input int unsigned sensor_dim,
                                               input int unsigned image_dim);
      int unsigned lim;
      lim = sensor_dim - image_dim;
      return (start > lim) ? lim : start;
   endfunction

endpackage

// File: rtl/crop_window_counter.sv
// Sensor-position counter for the frame sequencer. Tracks the column/row of
// the next accepted pixel and flags whether it lies in the crop window, is
// the last pixel of the window, or is the last pixel of the sensor frame.
module crop_window_counter
   import downsampler_seq_pkg::*;
#(
   parameter int SENSOR_WIDTH  = 640,
   parameter int SENSOR_HEIGHT = 480,
   parameter int IMAGE_WIDTH   = 320,
   parameter int IMAGE_HEIGHT  = 240,
   localparam int COL_W = col_w(SENSOR_WIDTH),
   localparam int ROW_W = row_w(SENSOR_HEIGHT)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             advance_i,
   input  logic [COL_W-1:0] x_start_i,
   input  logic [ROW_W-1:0] y_start_i,
   output logic             in_window_o,
   output logic             frame_last_o,
   output logic             window_last_o
);

   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(SENSOR_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(SENSOR_HEIGHT - 1);
   localparam logic [COL_W:0]   IMG_W_EXT = (COL_W + 1)'(IMAGE_WIDTH);
   localparam logic [ROW_W:0]   IMG_H_EXT = (ROW_W + 1)'(IMAGE_HEIGHT);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;

   // One extra bit so x_start+IMAGE_WIDTH cannot wrap when the sensor size is a power of two.
   logic [COL_W:0] col_ext, x_lo, x_hi;
   logic [ROW_W:0] row_ext, y_lo, y_hi;

   // Next position: clear has priority over a pixel accepted in the same cycle.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clear_i) begin
         col_d = '0;
         row_d = '0;
      end else if (advance_i) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // Position registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   // Window bounds and position flags for the pixel presented this cycle.
   always_comb begin
      col_ext       = {1'b0, col_q};
      row_ext       = {1'b0, row_q};
      x_lo          = {1'b0, x_start_i};
      y_lo          = {1'b0, y_start_i};
      x_hi          = x_lo + IMG_W_EXT;
      y_hi          = y_lo + IMG_H_EXT;
      in_window_o   = (col_ext >= x_lo) && (col_ext < x_hi) &&
                      (row_ext >= y_lo) && (row_ext < y_hi);
      window_last_o = (col_ext == x_hi - 1'b1) && (row_ext == y_hi - 1'b1);
      frame_last_o  = (col_q == COL_LAST) && (row_q == ROW_LAST);
   end

endmodule

// File: rtl/downsampler_frame_sequencer.sv
// Frame-level controller in front of grayscale_downsampler: crops a window
// out of the sensor stream, pulses the downsampler reset before each frame,
// decimates frames by a programmable skip factor and resynchronises on
// malformed frames.
// Optional build macro DS_SEQ_STATS_EN adds saturating frame statistics
// outputs (frames_passed, frames_skipped, frames_errored).
module downsampler_frame_sequencer
   import downsampler_seq_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int SENSOR_WIDTH    = 640,
   parameter int SENSOR_HEIGHT   = 480,
   parameter int IMAGE_WIDTH     = 320,
   parameter int IMAGE_HEIGHT    = 240,
   parameter int DS_RESET_CYCLES = 2,
   localparam int COL_W = col_w(SENSOR_WIDTH),
   localparam int ROW_W = row_w(SENSOR_HEIGHT)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cam_valid,
   input  logic                  cam_vsync,
   input  logic [DATA_WIDTH-1:0] cam_data,
   input  logic [COL_W-1:0]      cfg_x_start,
   input  logic [ROW_W-1:0]      cfg_y_start,
   input  logic [3:0]            cfg_frame_skip,
   output logic                  ds_reset,
   output logic                  ds_valid,
   output logic                  ds_vsync,
   output logic [DATA_WIDTH-1:0] ds_data,
   output logic                  frame_done,
   output logic                  frame_error,
   output logic                  busy
`ifdef DS_SEQ_STATS_EN
   ,
   output logic [STATS_W-1:0]    frames_passed,
   output logic [STATS_W-1:0]    frames_skipped,
   output logic [STATS_W-1:0]    frames_errored
`endif
);

   localparam int                ARM_W    = $clog2(DS_RESET_CYCLES + 1);
   localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(DS_RESET_CYCLES - 1);

   seq_state_e       state_q, state_d;
   logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
   logic [3:0]       skip_q, skip_d;
   logic [COL_W-1:0] x_start_q, x_start_d;
   logic [ROW_W-1:0] y_start_q, y_start_d;

   logic                  vsync_q;
   logic                  seen_clk_q;
   logic                  ds_reset_q;
   logic                  ds_valid_q;
   logic [DATA_WIDTH-1:0] ds_data_q;
   logic                  frame_done_q;
   logic                  frame_error_q;
   logic                  busy_q;

   logic vs_rise;
   logic frame_end;
   logic start_frame;
   logic cnt_clear;
   logic cnt_advance;
   logic fwd;
   logic err;
   logic in_window;
   logic frame_last;
   logic window_last;

   // The very first edge after reset has no valid previous vsync to compare against.
   assign vs_rise   = cam_vsync & ~vsync_q & seen_clk_q;
   assign frame_end = cam_valid & frame_last;

   crop_window_counter #(
      .SENSOR_WIDTH  (SENSOR_WIDTH),
      .SENSOR_HEIGHT (SENSOR_HEIGHT),
      .IMAGE_WIDTH   (IMAGE_WIDTH),
      .IMAGE_HEIGHT  (IMAGE_HEIGHT)
   ) u_window (
      .clock         (clock),
      .reset         (reset),
      .clear_i       (cnt_clear),
      .advance_i     (cnt_advance),
      .x_start_i     (x_start_q),
      .y_start_i     (y_start_q),
      .in_window_o   (in_window),
      .frame_last_o  (frame_last),
      .window_last_o (window_last)
   );

   // Next-state logic; a vsync rise (new frame start) overrides every other transition.
   always_comb begin
      state_d     = state_q;
      arm_cnt_d   = arm_cnt_q;
      skip_d      = skip_q;
      x_start_d   = x_start_q;
      y_start_d   = y_start_q;
      start_frame = 1'b0;
      cnt_clear   = 1'b0;
      cnt_advance = 1'b0;
      fwd         = 1'b0;
      err         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            start_frame = vs_rise;
         end
         ST_ARM: begin
            cnt_advance = cam_valid;
            if (arm_cnt_q == ARM_LAST) begin
               state_d = ST_ACTIVE;
            end else begin
               arm_cnt_d = arm_cnt_q + 1'b1;
            end
            if (frame_end) begin
               state_d = ST_IDLE;
            end
            if (vs_rise) begin
               err         = ~frame_end;
               start_frame = 1'b1;
            end
         end
         ST_ACTIVE, ST_SKIP: begin
            cnt_advance = cam_valid;
            fwd         = (state_q == ST_ACTIVE) & cam_valid & in_window;
            if (frame_end) begin
               state_d = ST_IDLE;
            end
            // A rise coinciding with the final pixel is a clean back-to-back frame.
            if (vs_rise) begin
               err         = ~frame_end;
               start_frame = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (start_frame) begin
         cnt_clear = 1'b1;
         arm_cnt_d = '0;
         x_start_d = COL_W'(clamp_start(32'(cfg_x_start), SENSOR_WIDTH, IMAGE_WIDTH));
         y_start_d = ROW_W'(clamp_start(32'(cfg_y_start), SENSOR_HEIGHT, IMAGE_HEIGHT));
         if (skip_q == 4'd0) begin
            state_d = ST_ARM;
            skip_d  = cfg_frame_skip;
         end else begin
            state_d = ST_SKIP;
            skip_d  = skip_q - 1'b1;
         end
      end
   end

   // Sequencer state, ARM timer, skip counter and latched crop origin.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         arm_cnt_q <= '0;
         skip_q    <= '0;
         x_start_q <= '0;
         y_start_q <= '0;
      end else begin
         state_q   <= state_d;
         arm_cnt_q <= arm_cnt_d;
         skip_q    <= skip_d;
         x_start_q <= x_start_d;
         y_start_q <= y_start_d;
      end
   end

   // Registered outputs; ds_reset/busy follow the state entered on this edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vsync_q       <= 1'b0;
         seen_clk_q    <= 1'b0;
         ds_reset_q    <= 1'b1;
         ds_valid_q    <= 1'b0;
         ds_data_q     <= '0;
         frame_done_q  <= 1'b0;
         frame_error_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         vsync_q       <= cam_vsync;
         seen_clk_q    <= 1'b1;
         ds_reset_q    <= (state_d == ST_IDLE) || (state_d == ST_ARM);
         ds_valid_q    <= fwd;
         if (fwd) begin
            ds_data_q <= cam_data;
         end
         frame_done_q  <= fwd & window_last;
         frame_error_q <= err;
         busy_q        <= (state_d != ST_IDLE);
      end
   end

   assign ds_reset    = ds_reset_q;
   assign ds_valid    = ds_valid_q;
   assign ds_vsync    = vsync_q;
   assign ds_data     = ds_data_q;
   assign frame_done  = frame_done_q;
   assign frame_error = frame_error_q;
   assign busy        = busy_q;

`ifdef DS_SEQ_STATS_EN
   logic [2:0] stat_inc;
   logic       skip_end;

   // A skipped frame is only tallied when it runs to its natural end.
   assign skip_end = (state_q == ST_SKIP) & frame_end;
   assign stat_inc = {err, skip_end, fwd & window_last};

   for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      logic [STATS_W-1:0] cnt_q;

      // Saturating event counter.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            cnt_q <= '0;
         end else if (stat_inc[gi] && (cnt_q != {STATS_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign frames_passed  = g_stat[0].cnt_q;
   assign frames_skipped = g_stat[1].cnt_q;
   assign frames_errored = g_stat[2].cnt_q;
`endif

endmodule

// File: tb/tb_downsampler_frame_sequencer.sv
// Randomised self-checking bench for downsampler_frame_sequencer on a reduced
// 16x12 sensor with an 8x6 window. A frame-level model derives every expected
// output from pixel indices, the crop rules and the skip sequence.
module tb_downsampler_frame_sequencer;

   localparam int DW  = 8;
   localparam int SW  = 16;
   localparam int SH  = 12;
   localparam int IW  = 8;
   localparam int IH  = 6;
   localparam int DSR = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cam_valid = 1'b0;
   logic          cam_vsync = 1'b0;
   logic [DW-1:0] cam_data = '0;
   logic [3:0]    cfg_x_start = '0;
   logic [3:0]    cfg_y_start = '0;
   logic [3:0]    cfg_frame_skip = '0;
   logic          ds_reset, ds_valid, ds_vsync, frame_done, frame_error, busy;
   logic [DW-1:0] ds_data;
`ifdef DS_SEQ_STATS_EN
   logic [15:0]   frames_passed, frames_skipped, frames_errored;
`endif

   downsampler_frame_sequencer #(
      .DATA_WIDTH      (DW),
      .SENSOR_WIDTH    (SW),
      .SENSOR_HEIGHT   (SH),
      .IMAGE_WIDTH     (IW),
      .IMAGE_HEIGHT    (IH),
      .DS_RESET_CYCLES (DSR)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .cam_valid      (cam_valid),
      .cam_vsync      (cam_vsync),
      .cam_data       (cam_data),
      .cfg_x_start    (cfg_x_start),
      .cfg_y_start    (cfg_y_start),
      .cfg_frame_skip (cfg_frame_skip),
      .ds_reset       (ds_reset),
      .ds_valid       (ds_valid),
      .ds_vsync       (ds_vsync),
      .ds_data        (ds_data),
      .frame_done     (frame_done),
      .frame_error    (frame_error),
`ifdef DS_SEQ_STATS_EN
      .frames_passed  (frames_passed),
      .frames_skipped (frames_skipped),
      .frames_errored (frames_errored),
`endif
      .busy           (busy)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Frame-level reference model state.
   bit m_seen, m_prev_vs, m_in_frame, m_pass;
   int m_offset, m_pix, m_xs, m_ys, m_skip;
   int m_passed, m_skipped, m_errored;

   // Observation accumulators for per-test totals.
   int obs_cnt, obs_first, obs_done, obs_err;
   int obs_min_col, obs_max_col, obs_min_row, obs_max_row;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_seen = 0; m_prev_vs = 0; m_in_frame = 0; m_pass = 0;
      m_offset = 0; m_pix = 0; m_xs = 0; m_ys = 0; m_skip = 0;
      m_passed = 0; m_skipped = 0; m_errored = 0;
   endtask

   task automatic clear_obs();
      obs_cnt = 0; obs_first = -1; obs_done = 0; obs_err = 0;
      obs_min_col = 999; obs_max_col = -1; obs_min_row = 999; obs_max_row = -1;
   endtask

   // Drive one cycle of sensor input, predict the outputs after the edge, compare.
   task automatic cycle(input bit v, input bit vs, input logic [DW-1:0] d);
      bit            rise, e_valid, e_done, e_err, e_rst, e_busy;
      logic [DW-1:0] e_data;
      int            col, row;
      cam_valid = v; cam_vsync = vs; cam_data = d;
      e_valid = 0; e_done = 0; e_err = 0; e_data = '0;
      rise = vs && !m_prev_vs && m_seen;
      m_prev_vs = vs;
      m_seen = 1;
      if (m_in_frame) begin
         m_offset++;
         if (v) begin
            col = m_pix % SW;
            row = m_pix / SW;
            if (m_pass && m_offset > DSR && col >= m_xs && col < m_xs + IW &&
                row >= m_ys && row < m_ys + IH) begin
               e_valid = 1;
               e_data  = d;
               e_done  = (col == m_xs + IW - 1) && (row == m_ys + IH - 1);
               if (e_done) m_passed++;
            end
            m_pix++;
            if (m_pix == SW * SH) begin
               m_in_frame = 0;
               if (!m_pass) m_skipped++;
            end
         end
      end
      if (rise) begin
         if (m_in_frame) begin
            e_err = 1;
            m_errored++;
         end
         m_in_frame = 1;
         m_offset = 0;
         m_pix = 0;
         m_xs = (cfg_x_start > SW - IW) ? SW - IW : int'(cfg_x_start);
         m_ys = (cfg_y_start > SH - IH) ? SH - IH : int'(cfg_y_start);
         if (m_skip == 0) begin
            m_pass = 1;
            m_skip = cfg_frame_skip;
         end else begin
            m_pass = 0;
            m_skip--;
         end
      end
      e_rst  = !m_in_frame || (m_pass && m_offset < DSR);
      e_busy = m_in_frame;
      @(posedge clock);
      #1;
      check_eq("ds_valid", ds_valid, e_valid);
      if (e_valid) check_eq("ds_data", ds_data, e_data);
      check_eq("frame_done", frame_done, e_done);
      check_eq("frame_error", frame_error, e_err);
      check_eq("ds_vsync", ds_vsync, vs);
      check_eq("ds_reset", ds_reset, e_rst);
      check_eq("busy", busy, e_busy);
      if (ds_valid) begin
         obs_cnt++;
         if (obs_first < 0) obs_first = ds_data;
         if (int'(ds_data) % 16 < obs_min_col) obs_min_col = int'(ds_data) % 16;
         if (int'(ds_data) % 16 > obs_max_col) obs_max_col = int'(ds_data) % 16;
         if (int'(ds_data) / 16 < obs_min_row) obs_min_row = int'(ds_data) / 16;
         if (int'(ds_data) / 16 > obs_max_row) obs_max_row = int'(ds_data) / 16;
      end
      if (frame_done) obs_done++;
      if (frame_error) obs_err++;
   endtask

   // Stream one (possibly partial) sensor frame. Coordinate-coded data is row*16+col.
   task automatic run_frame(input bit do_rise, input int npix, input bit rise_on_last,
                            input int arm_gap, input bit rnd_data, input bit jitter_cfg);
      int            sent, t;
      bit            v, vs;
      logic [DW-1:0] d;
      sent = 0;
      t = 1;
      if (do_rise) begin
         cycle(0, 0, '0);
         cycle(0, 1, '0);
      end
      while (sent < npix) begin
         v  = (t <= arm_gap) ? 1'b0 : ($urandom_range(0, 3) != 0);
         vs = (t < 3);
         if (v && sent == npix - 1 && rise_on_last) vs = 1;
         d = rnd_data ? DW'($urandom) : DW'((sent / SW) * 16 + (sent % SW));
         if (jitter_cfg && $urandom_range(0, 15) == 0) begin
            cfg_x_start = 4'($urandom);
            cfg_y_start = 4'($urandom);
         end
         cycle(v, vs, d);
         if (v) sent++;
         t++;
      end
   endtask

   initial begin
      model_reset();
      clear_obs();

      // Reset held: downsampler held in reset, nothing forwarded.
      #2 reset = 1'b0;
      repeat (3) begin
         @(posedge clock);
         #1;
         check_eq("rst_ds_reset", ds_reset, 1);
         check_eq("rst_ds_valid", ds_valid, 0);
         check_eq("rst_busy", busy, 0);
         check_eq("rst_frame_done", frame_done, 0);
      end
      reset = 1'b1;
      repeat (3) cycle(0, 0, '0);

      // Full frame with a (5,3) window origin.
      cfg_x_start = 4'd5; cfg_y_start = 4'd3; cfg_frame_skip = 4'd0;
      clear_obs();
      run_frame(1, SW * SH, 0, DSR, 0, 0);
      repeat (2) cycle(0, 0, '0);
      check_eq("t1_count", obs_cnt, IW * IH);
      check_eq("t1_first_data", obs_first, 3 * 16 + 5);
      check_eq("t1_done_pulses", obs_done, 1);
      $display("frame t1 forwarded=%0d first=%0d", obs_cnt, obs_first);

      // Skip factor 2 over six frames: frames 0 and 3 pass.
      cfg_x_start = 4'd0; cfg_y_start = 4'd0; cfg_frame_skip = 4'd2;
      for (int f = 0; f < 6; f++) begin
         clear_obs();
         run_frame(1, SW * SH, 0, DSR, 0, 0);
         check_eq($sformatf("skip_f%0d_count", f), obs_cnt, (f % 3 == 0) ? IW * IH : 0);
         $display("frame skip%0d forwarded=%0d", f, obs_cnt);
      end
      cfg_frame_skip = 4'd0;

      // Early vsync after 100 pixels: error, then a clean full frame.
      cfg_x_start = 4'd2; cfg_y_start = 4'd2;
      run_frame(1, 100, 0, DSR, 0, 0);
      clear_obs();
      run_frame(1, SW * SH, 0, DSR, 0, 0);
      check_eq("err_pulses", obs_err, 1);
      check_eq("err_next_count", obs_cnt, IW * IH);
      $display("frame err errors=%0d forwarded=%0d", obs_err, obs_cnt);

      // Clamped origin: x 13 -> 8, y 10 -> 6.
      cfg_x_start = 4'd13; cfg_y_start = 4'd10;
      clear_obs();
      run_frame(1, SW * SH, 0, DSR, 0, 0);
      check_eq("clamp_count", obs_cnt, IW * IH);
      check_eq("clamp_min_col", obs_min_col, SW - IW);
      check_eq("clamp_max_col", obs_max_col, SW - 1);
      check_eq("clamp_min_row", obs_min_row, SH - IH);
      check_eq("clamp_max_row", obs_max_row, SH - 1);
      $display("frame clamp cols=%0d..%0d rows=%0d..%0d", obs_min_col, obs_max_col, obs_min_row, obs_max_row);

      // Bottom-right window with the next vsync rise on the final pixel.
      cfg_x_start = 4'd8; cfg_y_start = 4'd6;
      clear_obs();
      run_frame(1, SW * SH, 1, DSR, 0, 0);
      check_eq("coinc_done", obs_done, 1);
      check_eq("coinc_err", obs_err, 0);
      clear_obs();
      run_frame(0, SW * SH, 0, DSR, 0, 0);
      check_eq("coinc_next_count", obs_cnt, IW * IH);
      check_eq("coinc_next_err", obs_err, 0);
      $display("frame coinc forwarded=%0d", obs_cnt);

      // Asynchronous reset while a window pixel is on the output.
      cfg_x_start = 4'd0; cfg_y_start = 4'd0;
      run_frame(1, 52, 0, DSR, 0, 0);
      #2 reset = 1'b0;
      #1;
      check_eq("arst_ds_reset", ds_reset, 1);
      check_eq("arst_ds_valid", ds_valid, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_ds_vsync", ds_vsync, 0);
      cam_valid = 1'b1;
      cam_vsync = 1'b1;
      repeat (3) begin
         @(posedge clock);
         #1;
         check_eq("arst_hold_done", frame_done, 0);
         check_eq("arst_hold_valid", ds_valid, 0);
      end
      cam_valid = 1'b0;
      model_reset();
      reset = 1'b1;
      // vsync already high when reset releases: no frame start.
      repeat (3) cycle(0, 1, '0);
      cycle(0, 0, '0);
      $display("arst done");

      // Randomised frames: random window, skip, ARM gap, data and partial frames.
      for (int f = 0; f < 8; f++) begin
         int npix;
         cfg_x_start    = 4'($urandom);
         cfg_y_start    = 4'($urandom);
         cfg_frame_skip = 4'($urandom_range(0, 1));
         npix = ($urandom_range(0, 3) == 0 && f < 7) ? $urandom_range(1, SW * SH - 1) : SW * SH;
         clear_obs();
         run_frame(1, npix, 0, $urandom_range(0, 3), 1, 1);
         $display("frame rnd%0d pixels=%0d forwarded=%0d errors=%0d", f, npix, obs_cnt, obs_err);
      end
      repeat (3) cycle(0, 0, '0);

`ifdef DS_SEQ_STATS_EN
      check_eq("stat_passed", frames_passed, m_passed);
      check_eq("stat_skipped", frames_skipped, m_skipped);
      check_eq("stat_errored", frames_errored, m_errored);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
